// File: rtl/type_buffer.sv
// Typed-text buffer for the VGA renderer: collects keystrokes, compares them live
// against the current target word, keeps keystroke statistics and requests word advances.
module type_buffer #(
  parameter int BUF_CHARS  = 25,
  parameter int WORD_CHARS = 15,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    key_valid,
  input  logic [4:0]              key_code,
  output logic                    key_ready,
  input  logic [5*WORD_CHARS-1:0] target,
  input  logic [4:0]              target_len,
  // "type" is a reserved word, so the typed-character array is called typed
  output logic [5*BUF_CHARS-1:0]  typed,
  output logic [4:0]              correct,
  output logic [4:0]              tot,
  output logic                    word_adv,
  output logic                    started,
  output logic [9:0]              words_done,
  output logic [CNT_W-1:0]        key_total,
  output logic [CNT_W-1:0]        key_good,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {TYPING = 2'd0, ADV = 2'd1, SETTLE = 2'd2} state_t;

  localparam int              CMP_CHARS = (BUF_CHARS < WORD_CHARS) ? BUF_CHARS : WORD_CHARS;
  localparam logic [4:0]      BUF_N     = 5'(BUF_CHARS);
  localparam logic [4:0]      WORD_N    = 5'(WORD_CHARS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]      K_SPACE   = 5'd27;
  localparam logic [4:0]      K_BKSP    = 5'd28;

  state_t                 state, state_next;
  logic [5*BUF_CHARS-1:0] buf_next;
  logic [4:0]             tot_next, correct_next, lim, tchar;
  logic                   started_next, word_adv_next, accept, is_letter;
  logic [9:0]             words_next;
  logic [CNT_W-1:0]       total_next, good_next;

  // Handshake: a key transfers on a rising clk edge where key_valid && key_ready;
  // key_ready depends only on en, clear, rst and the registered state, never on key_valid.
  assign key_ready = rst && en && (state == TYPING) && !clear;
  assign accept    = key_valid && key_ready;
  assign is_letter = (key_code >= 5'd1) && (key_code <= 5'd26);
  assign state_dbg = state;

  always_comb begin
    state_next   = state;
    buf_next     = typed;
    tot_next     = tot;
    started_next = started;
    words_next   = words_done;
    total_next   = key_total;
    good_next    = key_good;
    tchar        = '0;
    if (tot < WORD_N) tchar = target[5*tot +: 5];

    case (state)
      ADV:     state_next = SETTLE;
      SETTLE:  state_next = TYPING;
      default: state_next = TYPING;
    endcase

    if (accept) begin
      if (is_letter) begin
        total_next = key_total + CNT_ONE;
        if (tot < BUF_N) begin
          buf_next[5*tot +: 5] = key_code;
          tot_next     = tot + 5'd1;
          started_next = 1'b1;
          if ((correct == tot) && (tot < target_len) && (key_code == tchar))
            good_next = key_good + CNT_ONE;
        end
      end else if (key_code == K_BKSP) begin
        if (tot != 5'd0) begin
          buf_next[5*(tot - 5'd1) +: 5] = 5'd0;
          tot_next = tot - 5'd1;
        end
      end else if (key_code == K_SPACE) begin
        total_next = key_total + CNT_ONE;
        if ((correct == tot) && (tot == target_len)) begin
          good_next  = key_good + CNT_ONE;
          buf_next   = '0;
          tot_next   = 5'd0;
          words_next = words_done + 10'd1;
          state_next = ADV;
        end
      end
    end

    if (clear) begin
      state_next   = TYPING;
      buf_next     = '0;
      tot_next     = 5'd0;
      started_next = 1'b0;
      words_next   = 10'd0;
      total_next   = '0;
      good_next    = '0;
    end

    word_adv_next = (state_next == ADV);
  end

  // Matching prefix is derived from the next buffer so it lands on the same edge as the key.
  always_comb begin
    logic run;
    run          = 1'b1;
    correct_next = 5'd0;
    lim          = (tot_next < target_len) ? tot_next : target_len;
    for (int p = 0; p < CMP_CHARS; p++) begin
      if (run && (5'(p) < lim) && (buf_next[5*p +: 5] == target[5*p +: 5]))
        correct_next = correct_next + 5'd1;
      else
        run = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= TYPING;
      typed      <= '0;
      tot        <= 5'd0;
      correct    <= 5'd0;
      word_adv   <= 1'b0;
      started    <= 1'b0;
      words_done <= 10'd0;
      key_total  <= '0;
      key_good   <= '0;
    end else begin
      state      <= state_next;
      typed      <= buf_next;
      tot        <= tot_next;
      correct    <= correct_next;
      word_adv   <= word_adv_next;
      started    <= started_next;
      words_done <= words_next;
      key_total  <= total_next;
      key_good   <= good_next;
    end
  end

endmodule
